// File: rtl/addsub_pkg.sv
// Shared types for the pipelined adder/subtractor: op encoding, result flags, chunk sizing.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } addsub_flags_t;

  // Bits resolved per pipeline stage; width must divide evenly by stages.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit adder slice with carry in/out; one instance per pipeline stage.
module addsub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/sub resolving one chunk per stage; latency STAGES, global stall on backpressure.
// Defining ADDSUB_SATURATE_EN adds a sat input that clamps signed overflow in the final stage.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADDSUB_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;
  localparam int MSB   = WIDTH - 1;

  logic                          adv;
  logic [STAGES-1:0]             vld_s, vld_q;
  logic [STAGES-1:0]             cy_s, cy_q;
  logic [STAGES-1:0]             cout_w;
  logic [STAGES-1:0][CHUNK-1:0]  sum_w;
  logic [STAGES-1:0][WIDTH-1:0]  a_s, a_q;
  logic [STAGES-1:0][WIDTH-1:0]  b_s, b_q;
  logic [STAGES-1:0][WIDTH-1:0]  r_s, r_q, r_d;
  logic [WIDTH-1:0]              raw_res;
  logic [WIDTH-1:0]              fin_res;
  addsub_flags_t                 flags_d, flags_q;
`ifdef ADDSUB_SATURATE_EN
  logic [STAGES-1:0]             sat_s, sat_q;
`endif

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign result    = r_q[LAST];
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;

  // Stage k consumes the registers of stage k-1; stage 0 takes the ports, with b pre-inverted for SUB.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    if (k == 0) begin : g_in
      assign vld_s[0] = in_valid;
      assign a_s[0]   = a;
      assign b_s[0]   = (addsub_op_t'(op) == OP_SUB) ? ~b : b;
      assign cy_s[0]  = (addsub_op_t'(op) == OP_SUB);
      assign r_s[0]   = '0;
`ifdef ADDSUB_SATURATE_EN
      assign sat_s[0] = sat;
`endif
    end else begin : g_fwd
      assign vld_s[k] = vld_q[k-1];
      assign a_s[k]   = a_q[k-1];
      assign b_s[k]   = b_q[k-1];
      assign cy_s[k]  = cy_q[k-1];
      assign r_s[k]   = r_q[k-1];
`ifdef ADDSUB_SATURATE_EN
      assign sat_s[k] = sat_q[k-1];
`endif
    end

    addsub_chunk #(
      .W(CHUNK)
    ) u_chunk (
      .a_i   (a_s[k][k*CHUNK +: CHUNK]),
      .b_i   (b_s[k][k*CHUNK +: CHUNK]),
      .cin_i (cy_s[k]),
      .sum_o (sum_w[k]),
      .cout_o(cout_w[k])
    );
  end

  always_comb begin
    r_d = r_s;
    for (int k = 0; k < STAGES; k++) begin
      r_d[k][k*CHUNK +: CHUNK] = sum_w[k];
    end
    raw_res          = r_d[LAST];
    flags_d.carry    = cout_w[LAST];
    flags_d.overflow = (a_s[LAST][MSB] == b_s[LAST][MSB]) && (raw_res[MSB] != a_s[LAST][MSB]);
    fin_res          = raw_res;
`ifdef ADDSUB_SATURATE_EN
    if (sat_s[LAST] && flags_d.overflow) begin
      fin_res = a_s[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    flags_d.zero = ~|fin_res;
    r_d[LAST]    = fin_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      cy_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      flags_q <= '0;
`ifdef ADDSUB_SATURATE_EN
      sat_q   <= '0;
`endif
    end else if (adv) begin
      vld_q   <= vld_s;
      cy_q    <= cout_w;
      a_q     <= a_s;
      b_q     <= b_s;
      r_q     <= r_d;
      flags_q <= flags_d;
`ifdef ADDSUB_SATURATE_EN
      sat_q   <= sat_s;
`endif
    end
  end

  // Operands and carry leaving the final stage have no consumer.
  logic unused_tail;
`ifdef ADDSUB_SATURATE_EN
  assign unused_tail = ^{a_q[LAST], b_q[LAST], cy_q[LAST], sat_q[LAST]};
`else
  assign unused_tail = ^{a_q[LAST], b_q[LAST], cy_q[LAST]};
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: table vectors and random streams checked through an in-order scoreboard.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sat;
    logic [31:0] res;
    logic        c;
    logic        ov;
    logic        z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] a, b;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        carry, overflow, zero;
`ifdef ADDSUB_SATURATE_EN
  logic        sat;
`endif
  logic        s1_rdy, s1_vld, s1_c, s1_ov, s1_z;
  logic [31:0] s1_res;
  logic        s8_rdy, s8_vld, s8_c, s8_ov, s8_z;
  logic [31:0] s8_res;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_emit = 0;
  vec_t cur;
  vec_t sb[$];
  vec_t tbl[$];
  int   acc_cyc[$];
  int   emit_cyc[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
`ifdef ADDSUB_SATURATE_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_rdy), .op(op), .a(a), .b(b),
`ifdef ADDSUB_SATURATE_EN
    .sat(sat),
`endif
    .out_valid(s1_vld), .out_ready(1'b1), .result(s1_res), .carry(s1_c),
    .overflow(s1_ov), .zero(s1_z)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s8_rdy), .op(op), .a(a), .b(b),
`ifdef ADDSUB_SATURATE_EN
    .sat(sat),
`endif
    .out_valid(s8_vld), .out_ready(1'b1), .result(s8_res), .carry(s8_c),
    .overflow(s8_ov), .zero(s8_z)
  );

  function automatic vec_t mk(input logic o, input logic [31:0] av, input logic [31:0] bv,
                              input logic s, input logic [31:0] r, input logic c,
                              input logic ov, input logic z);
    vec_t v;
    v.op = o; v.a = av; v.b = bv; v.sat = s; v.res = r; v.c = c; v.ov = ov; v.z = z;
    return v;
  endfunction

  function automatic vec_t model(input logic o, input logic [31:0] av, input logic [31:0] bv,
                                 input logic s);
    vec_t        v;
    logic [31:0] bb;
    logic [32:0] t;
    bb = o ? ~bv : bv;
    t  = {1'b0, av} + {1'b0, bb} + {32'd0, o};
    v.op = o; v.a = av; v.b = bv; v.sat = s;
    v.res = t[31:0];
    v.c   = t[32];
    v.ov  = (av[31] == bb[31]) && (t[31] != av[31]);
`ifdef ADDSUB_SATURATE_EN
    if (s && v.ov) v.res = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    v.z = (v.res == 32'd0);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are decided at the negedge from settled handshake signals.
  always @(negedge clk) begin
    vec_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got result %h with nothing outstanding", result);
        end else begin
          e = sb.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_carry", {31'd0, carry}, {31'd0, e.c});
          chk("sb_overflow", {31'd0, overflow}, {31'd0, e.ov});
          chk("sb_zero", {31'd0, zero}, {31'd0, e.z});
        end
        emit_cyc.push_back(cyc);
        n_emit++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(input vec_t v);
    cur = v; op = v.op; a = v.a; b = v.b;
`ifdef ADDSUB_SATURATE_EN
    sat = v.sat;
`endif
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    bit acc;
    int g;
    drive(v);
    acc = 1'b0;
    g   = 0;
    while (!acc && g < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: accepted %0d required 1", acc);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic lat_test(input vec_t v);
    int l4, l1, l8;
    repeat (10) @(posedge clk);
    #1;
    l4 = 0; l1 = 0; l8 = 0;
    drive(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid && l4 == 0) l4 = c;
      if (s1_vld && l1 == 0) begin
        l1 = c;
        chk("s1_result", s1_res, v.res);
        chk("s1_overflow", {31'd0, s1_ov}, {31'd0, v.ov});
      end
      if (s8_vld && l8 == 0) begin
        l8 = c;
        chk("s8_result", s8_res, v.res);
        chk("s8_carry", {31'd0, s8_c}, {31'd0, v.c});
      end
      @(posedge clk);
      #1;
    end
    chk("latency_s4", l4, 4);
    chk("latency_s1", l1, 1);
    chk("latency_s8", l8, 8);
    drain();
  endtask

  initial begin
    int n0, a0, e0;
    vec_t rv[$];

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
`ifdef ADDSUB_SATURATE_EN
    sat = 1'b0;
`endif
    tbl.push_back(mk(OP_ADD, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 0, 0, 0));
    tbl.push_back(mk(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 0, 1));
    tbl.push_back(mk(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1, 1, 0));
    tbl.push_back(mk(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0));
    tbl.push_back(mk(OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1, 0, 1));
    tbl.push_back(mk(OP_SUB, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 0, 0, 0));
    tbl.push_back(mk(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1, 1, 1));
    tbl.push_back(mk(OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 0, 0, 0));
    tbl.push_back(mk(OP_ADD, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 0, 0, 0));
    tbl.push_back(mk(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 0, 0, 0));
`ifdef ADDSUB_SATURATE_EN
    tbl.push_back(mk(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 0, 1, 0));
    tbl.push_back(mk(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1, 1, 0));
    tbl.push_back(mk(OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 0, 1, 0));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, carry, overflow, zero}, 32'd0);
    chk("rst_s8_out_valid", {31'd0, s8_vld}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    lat_test(tbl[0]);
`ifdef ADDSUB_SATURATE_EN
    lat_test(tbl[10]);
`endif

    // Back-to-back table stream: one result per cycle, in order.
    n0 = emit_cyc.size();
    a0 = acc_cyc.size();
    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
    drain();
    chk("stream_count", emit_cyc.size() - n0, tbl.size());
    if (emit_cyc.size() >= n0 + tbl.size() && acc_cyc.size() > a0) begin
      chk("stream_first_lat", emit_cyc[n0] - acc_cyc[a0], 4);
      chk("stream_span", emit_cyc[n0 + tbl.size() - 1] - emit_cyc[n0], tbl.size() - 1);
    end

    // 8 random ops with a 5-cycle consumer stall in the middle.
    for (int i = 0; i < 8; i++)
      rv.push_back(model(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1))));
    e0 = n_emit;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rv[i]);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          if (sb.size() != 0) chk("stall_hold_result", result, sb[0].res);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_emit_count", n_emit - e0, 8);

    // Reset with three ops in flight, the oldest already presented at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(model(OP_ADD, 32'h100 + i, 32'h1, 1'b0));
    @(posedge clk);
    #1;
    chk("rstmid_pre_valid", {31'd0, out_valid}, 32'd1);
    e0 = n_emit;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_no_emit", n_emit - e0, 0);
    send(model(OP_SUB, 32'h0000_1000, 32'h0000_0001, 1'b0));
    drain();
    chk("rstmid_new_op", n_emit - e0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
